// File: rtl/score_display_ctrl_pkg.sv
// Shared types and helpers for the score display controller.
// Holds the state encoding, the BCD score representation and the blank pattern.
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    // Packed hundreds-first, so a plain unsigned compare of two scores is numeric.
    typedef struct packed {
        bcd_t h;
        bcd_t t;
        bcd_t o;
    } bcd3_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd3_t bcd3_inc(input bcd3_t s);
        bcd3_t r;
        r = s;
        if (s.o != 4'd9) begin
            r.o = s.o + 4'd1;
        end else begin
            r.o = 4'd0;
            if (s.t != 4'd9) begin
                r.t = s.t + 4'd1;
            end else begin
                r.t = 4'd0;
                r.h = (s.h == 4'd9) ? 4'd0 : s.h + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic int bcd3_value(input bcd3_t s);
        return int'(s.h) * 100 + int'(s.t) * 10 + int'(s.o);
    endfunction

endpackage

// File: rtl/score_display_ctrl_seg7.sv
// BCD digit to active-low seven-segment decoder; bit 6 = g, bit 0 = a.
// Codes 10-15 never occur in the score registers and decode to blank.
module seg7
    import score_display_ctrl_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Game score keeper: IDLE/PLAY/OVER flow, saturating BCD score, high score,
// blinking score display after a game and leading-zero blanking on six HEX digits.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int MAX_SCORE    = 999,
    parameter bit LZ_BLANK     = 1'b1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       game_start,
    input  logic       score_inc,
    input  logic       game_over,
    output logic       playing,
    output logic       new_record,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_PLAY = 2'(PLAY);
    localparam logic [1:0] S_OVER = 2'(OVER);
    localparam int         CW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [1:0]    state;
    bcd3_t         score;
    bcd3_t         high;
    logic [CW-1:0] blink_cnt;
    logic          blink_phase;

    bcd3_t score_up;
    bcd3_t score_final;

    assign score_up    = (bcd3_value(score) >= MAX_SCORE) ? score : bcd3_inc(score);
    // A score_inc coinciding with game_over still counts toward the record.
    assign score_final = score_inc ? score_up : score;

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            score      <= '0;
            high       <= '0;
            new_record <= 1'b0;
        end else if (game_start) begin
            state      <= S_PLAY;
            score      <= '0;
            new_record <= 1'b0;
        end else if (state == S_PLAY) begin
            score <= score_final;
            if (game_over) begin
                state <= S_OVER;
                if (score_final > high) begin
                    high       <= score_final;
                    new_record <= 1'b1;
                end
            end
        end
    end

    // Counter and phase idle at zero outside OVER, so every entry starts visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == S_OVER && !game_start) begin
            if (blink_cnt == CW'(BLINK_CYCLES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end
    end

    assign playing = (state == S_PLAY);

    bcd_t       digit   [6];
    logic [6:0] seg_raw [6];
    logic       blank   [6];
    logic       score_hidden;

    assign digit[0] = score.o;
    assign digit[1] = score.t;
    assign digit[2] = score.h;
    assign digit[3] = high.o;
    assign digit[4] = high.t;
    assign digit[5] = high.h;

    for (genvar i = 0; i < 6; i++) begin : g_hex
        seg7 u_seg7 (
            .digit (digit[i]),
            .seg   (seg_raw[i])
        );
    end

    assign score_hidden = (state == S_OVER) && blink_phase;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 6; i++) blank[i] = 1'b0;
        if (LZ_BLANK) begin
            blank[2] = (score.h == 4'd0);
            blank[1] = (score.h == 4'd0) && (score.t == 4'd0);
            blank[5] = (high.h == 4'd0);
            blank[4] = (high.h == 4'd0) && (high.t == 4'd0);
        end
        if (score_hidden) begin
            blank[0] = 1'b1;
            blank[1] = 1'b1;
            blank[2] = 1'b1;
        end
    end

    assign HEX0 = blank[0] ? SEG_BLANK : seg_raw[0];
    assign HEX1 = blank[1] ? SEG_BLANK : seg_raw[1];
    assign HEX2 = blank[2] ? SEG_BLANK : seg_raw[2];
    assign HEX3 = blank[3] ? SEG_BLANK : seg_raw[3];
    assign HEX4 = blank[4] ? SEG_BLANK : seg_raw[4];
    assign HEX5 = blank[5] ? SEG_BLANK : seg_raw[5];

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed game scenarios plus random
// pulses, compared every cycle against an integer-level model of the game rules.
module tb_score_display_ctrl;

    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       game_start, score_inc, game_over;
    logic       playing, new_record;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    score_display_ctrl #(
        .BLINK_CYCLES (BLINK),
        .MAX_SCORE    (999),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .game_start (game_start),
        .score_inc  (score_inc),
        .game_over  (game_over),
        .playing    (playing),
        .new_record (new_record),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = play, 2 = over; scores as plain integers.
    int m_mode, m_score, m_high, m_over_cyc;
    bit m_rec;

    function automatic void model_reset();
        m_mode = 0; m_score = 0; m_high = 0; m_rec = 0; m_over_cyc = 0;
    endfunction

    function automatic void model_edge(input bit gs, input bit inc, input bit go);
        int s2;
        if (gs) begin
            m_mode = 1; m_score = 0; m_rec = 0;
        end else if (m_mode == 1) begin
            s2 = (inc && m_score < 999) ? m_score + 1 : m_score;
            m_score = s2;
            if (go) begin
                if (s2 > m_high) begin
                    m_high = s2; m_rec = 1;
                end
                m_mode = 2; m_over_cyc = 0;
            end
        end else if (m_mode == 2) begin
            m_over_cyc++;
        end
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // pos: 0 ones, 1 tens, 2 hundreds.
    function automatic logic [6:0] exp_digit(input int value, input int pos, input bit hidden);
        int d;
        d = (pos == 0) ? value % 10 : (pos == 1) ? (value / 10) % 10 : value / 100;
        if (hidden) return 7'b1111111;
        if (pos == 2 && value < 100) return 7'b1111111;
        if (pos == 1 && value < 10)  return 7'b1111111;
        return seg_of(d);
    endfunction

    task automatic compare_all(input string tag);
        bit hid;
        hid = (m_mode == 2) && (((m_over_cyc / BLINK) % 2) == 1);
        check({tag, ".playing"},    32'(playing),    32'(m_mode == 1));
        check({tag, ".new_record"}, 32'(new_record), 32'(m_rec));
        check({tag, ".HEX0"}, 32'(HEX0), 32'(exp_digit(m_score, 0, hid)));
        check({tag, ".HEX1"}, 32'(HEX1), 32'(exp_digit(m_score, 1, hid)));
        check({tag, ".HEX2"}, 32'(HEX2), 32'(exp_digit(m_score, 2, hid)));
        check({tag, ".HEX3"}, 32'(HEX3), 32'(exp_digit(m_high, 0, 1'b0)));
        check({tag, ".HEX4"}, 32'(HEX4), 32'(exp_digit(m_high, 1, 1'b0)));
        check({tag, ".HEX5"}, 32'(HEX5), 32'(exp_digit(m_high, 2, 1'b0)));
    endtask

    task automatic step(input string tag, input bit gs, input bit inc, input bit go);
        @(negedge clk);
        game_start = gs; score_inc = inc; game_over = go;
        @(posedge clk);
        model_edge(gs, inc, go);
        #1;
        compare_all(tag);
    endtask

    task automatic incs(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; game_start = 1'b0; score_inc = 1'b0; game_over = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        check("reset.HEX0_zero", 32'(HEX0), 32'h40);
        check("reset.HEX3_zero", 32'(HEX3), 32'h40);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle: pulses other than game_start have no effect.
        step("idle", 1'b0, 1'b0, 1'b0);
        step("idle_ign", 1'b0, 1'b1, 1'b1);

        // Ten points, each visible one cycle after its pulse.
        step("start1", 1'b1, 1'b0, 1'b0);
        incs("inc10", 10);
        check("inc10.HEX1_one", 32'(HEX1), 32'h79);

        // Score 12, then game_over with a simultaneous point: record 13, then blink.
        step("start2", 1'b1, 1'b0, 1'b0);
        incs("inc12", 12);
        step("over_rec", 1'b0, 1'b1, 1'b1);
        check("over_rec.flag", 32'(new_record), 32'd1);
        for (int i = 0; i < 12; i++) step("blink", 1'b0, 1'b1, 1'b1);

        // Score 5 does not beat 13.
        step("start3", 1'b1, 1'b0, 1'b0);
        incs("inc5", 5);
        step("over_norec", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("over_hold", 1'b0, 1'b0, 1'b0);

        // game_start beats game_over.
        step("start4", 1'b1, 1'b0, 1'b0);
        incs("inc3", 3);
        step("start_vs_over", 1'b1, 1'b0, 1'b1);
        check("start_vs_over.playing", 32'(playing), 32'd1);

        // Saturation at 999.
        incs("inc998", 998);
        incs("sat", 3);
        check("sat.HEX2_nine", 32'(HEX2), 32'h10);
        step("over_999", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step("over_999_blink", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-game at score 42, checked before the next edge.
        step("start5", 1'b1, 1'b0, 1'b0);
        incs("inc42", 42);
        @(negedge clk);
        game_start = 1'b0; score_inc = 1'b0; game_over = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step("after_rst", 1'b0, 1'b0, 1'b0);

        // Random pulses.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(99) < 6),
                 ($urandom_range(99) < 45),
                 ($urandom_range(99) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BLINK_CYCLES, 25_000_000, clock cycles per blink half-period in OVER.
- MAX_SCORE, 999, saturation value of the score counter.
- LZ_BLANK, 1, 1 = blank leading zero digits, 0 = show them.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- game_start, input, 1, single-cycle pulse that starts a new game.
- score_inc, input, 1, single-cycle pulse when the bird clears a pipe.
- game_over, input, 1, single-cycle pulse on collision.
- playing, output, 1, high while in state PLAY.
- new_record, output, 1, high in OVER when the last game set a new high score.
- HEX0..HEX2, output, 7 each, current score digits, ones to hundreds, active-low segments.
- HEX3..HEX5, output, 7 each, high-score digits, ones to hundreds, active-low segments.

Function
REQ-003 The score and high score SHALL each be three registered BCD digits, 0-9 per digit; no digit SHALL ever hold 10-15.
REQ-004 The FSM SHALL have exactly three states, IDLE, PLAY and OVER; the reset state SHALL be IDLE.
REQ-005 game_start in any state SHALL clear the score to 000, clear new_record and enter PLAY on the next edge.
REQ-006 In PLAY, score_inc SHALL increment the score by 1 with decimal carry (009->010, 099->100); the updated score SHALL appear on HEX2..HEX0 one cycle after the pulse.
REQ-007 The score SHALL saturate at MAX_SCORE; score_inc at MAX_SCORE SHALL leave it unchanged.
REQ-008 score_inc and game_over SHALL be ignored outside PLAY.
REQ-009 game_over in PLAY SHALL enter OVER; if the score, including any score_inc in the same cycle, is greater than the high score, the high score SHALL take that value and new_record SHALL be set, both on the same edge.
REQ-010 If the score equals or is below the high score, the high score SHALL be unchanged and new_record SHALL stay 0.
REQ-011 If game_start and game_over arrive together, game_start SHALL win.
REQ-012 In OVER, a blink counter SHALL toggle a blink phase every BLINK_CYCLES cycles; the phase SHALL be 0 (visible) on entry.
REQ-013 While the blink phase is 1, HEX2..HEX0 SHALL be blank (7'b1111111); HEX5..HEX3 SHALL never blink.
REQ-014 With LZ_BLANK=1, a hundreds digit of 0 SHALL be blank; a tens digit of 0 SHALL be blank when the hundreds digit is also 0; the ones digit SHALL never be blanked by this rule.
REQ-015 In IDLE, HEX2..HEX0 SHALL show the score (000 after reset), subject to REQ-014.
REQ-016 Segment encoding SHALL be active-low, with bit 6 = segment g and bit 0 = segment a.
REQ-017 Digit-to-segment decode SHALL be combinational from registered state; there SHALL be no additional output register.

Reset
REQ-018 Asserting reset_n low SHALL immediately set the state to IDLE, score to 000, high score to 000, new_record to 0, playing to 0, blink counter to 0 and blink phase to 0, including in the middle of a game or a blink period.
REQ-019 After reset, HEX0 and HEX3 SHALL show "0" (7'b1000000); with LZ_BLANK=1, all other HEX outputs SHALL be blank.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE, PLAY, OVER), the BCD digit typedef (logic [3:0]) and the blank pattern constant 7'b1111111.
REQ-021 The six HEX outputs SHALL each be driven through an instance of the existing seg7 decoder sub-module; blanking SHALL be a mux after each decoder.
REQ-022 The BCD increment with carry and saturation SHALL be in this module; no further sub-modules.

Verification (BLINK_CYCLES=4)
REQ-023 Reset, then idle: HEX0=7'b1000000, HEX3=7'b1000000, HEX1/2/4/5=7'b1111111, playing=0.
REQ-024 game_start, then 10 score_inc pulses: HEX1 shows "1", HEX0 shows "0", HEX2 is blank; each pulse becomes visible one cycle later.
REQ-025 Preload the score to 998, then apply 3 score_inc pulses: the score reads 999 after the second and third pulses (saturated).
REQ-026 Score 12, then game_over together with score_inc: high score becomes 013, new_record=1; HEX2..HEX0 are blank for cycles 5-8 after entry, visible for 1-4 and 9-12.
REQ-027 Next game with score 5, then game_over: high score stays 013, new_record=0; game_start and game_over in the same cycle leads to PLAY with score 000.
REQ-028 reset_n pulsed low mid-PLAY at score 42: all registers are cleared asynchronously before the next clock edge, and the REQ-023 outputs follow.
